// File: rtl/count_sched_pkg.sv
// Shared definitions for the count scheduler: FSM state encoding and default sizing.
package count_sched_pkg;

  localparam int unsigned DefaultNreq = 2;
  localparam int unsigned DefaultW    = 4;

  // Binary-encoded scheduler states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     : request vector, one bit per requester
//   ptr     : index of the highest-priority requester this round
//   gnt     : one-hot winner (all-zero when no request)
//   gnt_idx : binary index of the winner (0 when no request)
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int unsigned PtrW = $clog2(NREQ);

  int unsigned idx;
  logic        found;

  // Scan from ptr upwards, wrapping; first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx[PtrW-1:0];
      end
    end
  end

endmodule

// File: rtl/count_scheduler.sv
// Shares one W-bit up-counter between NREQ requesters. A round-robin winner is
// picked in IDLE, the counter is cleared in GRANT, counts up in RUN until it
// reaches the latched run length, and DONE pulses done to the owner for one cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   req   : level request per requester
//   len   : run length per requester, slice i = len[i*W +: W]
//   grant : one-hot owner of the counter, zero when idle
//   busy  : counter currently owned
//   count : shared counter value
//   done  : one-cycle completion pulse to the owner
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq,
  parameter int unsigned W    = DefaultW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [W-1:0]      count,
  output logic [NREQ-1:0]   done
);

  localparam int unsigned PtrW = $clog2(NREQ);

  sched_state_e      state_q;
  logic [PtrW-1:0]   owner_q;
  logic [PtrW-1:0]   ptr_q;
  logic [W-1:0]      term_q;
  logic [W-1:0]      count_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [PtrW-1:0]   arb_idx;
  logic [PtrW-1:0]   ptr_next;
  logic [W-1:0]      count_inc;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Priority moves to the requester just after the current owner.
  assign ptr_next  = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + PtrW'(1);
  assign count_inc = count_q + W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      term_q  <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            // count is cleared on entry so it already reads 0 during GRANT.
            owner_q <= arb_idx;
            term_q  <= len[arb_idx*W +: W];
            grant_q <= arb_gnt;
            count_q <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (!req[owner_q]) begin
            // Abandoned: release without a done pulse, count holds.
            grant_q <= '0;
            ptr_q   <= ptr_next;
            state_q <= StIdle;
          end else begin
            count_q <= '0;
            if (term_q == '0) begin
              done_q  <= grant_q;
              state_q <= StDone;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (!req[owner_q]) begin
            grant_q <= '0;
            ptr_q   <= ptr_next;
            state_q <= StIdle;
          end else begin
            count_q <= count_inc;
            if (count_inc == term_q) begin
              done_q  <= grant_q;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          // Run already complete; a req drop here does not cancel the pulse.
          grant_q <= '0;
          ptr_q   <= ptr_next;
          state_q <= StIdle;
        end
        default: begin
          grant_q <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);
  assign count = count_q;
  assign done  = done_q;

endmodule
